// File: rtl/ctrl_seq_pkg.sv
// Shared types and encodings for the decode-stage control-flow sequencer.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        OP_CALL = 2'b00,
        OP_RET  = 2'b01,
        OP_RETI = 2'b10,
        OP_RSVD = 2'b11
    } op_kind_e;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DRAIN      = 4'd1,
        S_PUSH_PC    = 4'd2,
        S_PUSH_FLAGS = 4'd3,
        S_VECTOR     = 4'd4,
        S_CALL_PUSH  = 4'd5,
        S_POP_FLAGS  = 4'd6,
        S_POP_PC     = 4'd7,
        S_RET_WAIT   = 4'd8
    } seq_state_e;

    localparam logic [1:0] MSRC_FLAGS = 2'b00;
    localparam logic [1:0] MSRC_PC    = 2'b01;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module irq_prio_enc #(
    parameter int N_IRQ = 1,
    parameter int ID_W  = 1
) (
    input  logic [N_IRQ-1:0] irq,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    always_comb begin
        valid = |irq;
        id    = '0;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/ctrl_flow_sequencer.sv
// Multi-cycle CALL / RET / RETI / interrupt-entry sequencer; stalls fetch and
// drives stack push/pop strobes word by word. Handshake: none, op is sampled only in IDLE.
module ctrl_flow_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int WORD_W   = 16,
    parameter int DRAIN    = 4,
    parameter int RET_WAIT = 2,
    parameter int N_IRQ    = 1,
    localparam int PC_WORDS = PC_W / WORD_W,
    localparam int IDX_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1,
    localparam int ID_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_kind,
    input  logic [N_IRQ-1:0] irq,
    output logic             busy,
    output logic             pc_write,
    output logic             clear_instruction,
    output logic             jump_uncond,
    output logic             mem_push,
    output logic             mem_pop,
    output logic [1:0]       mem_src_select,
    output logic [IDX_W-1:0] word_idx,
    output logic             flag_reg_select,
    output logic             pc_choose_memory,
    output logic             vector_load,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] irq_ack,
    output seq_state_e       state_dbg,
    output logic             in_isr_dbg
);

    localparam int CNT_MAX = max3(DRAIN, PC_WORDS, RET_WAIT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(PC_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_RETW  = CNT_W'(RET_WAIT - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_isr_q, in_isr_d;
    logic             reti_q, reti_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_sel;
    logic             last;

    irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio (
        .irq   (irq),
        .valid (irq_valid),
        .id    (irq_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            in_isr_q <= 1'b0;
            reti_q   <= 1'b0;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_isr_q <= in_isr_d;
            reti_q   <= reti_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_isr_d = in_isr_q;
        reti_d   = reti_q;
        irq_id_d = irq_id_q;
        last     = (cnt_q == '0);
        case (state_q)
            S_IDLE: begin
                // Interrupt beats a simultaneous op; decode re-fetches it later.
                if (irq_valid && !in_isr_q) begin
                    state_d  = S_DRAIN;
                    cnt_d    = CNT_DRAIN;
                    in_isr_d = 1'b1;
                    irq_id_d = irq_sel;
                end else if (op_valid) begin
                    case (op_kind_e'(op_kind))
                        OP_CALL: begin state_d = S_CALL_PUSH; cnt_d = CNT_WORDS; end
                        OP_RET:  begin state_d = S_POP_PC;    cnt_d = CNT_WORDS; end
                        OP_RETI: begin state_d = S_POP_FLAGS; cnt_d = '0; reti_d = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_DRAIN: begin
                if (last) begin state_d = S_PUSH_PC; cnt_d = CNT_WORDS; end
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_PUSH_PC: begin
                if (last) begin state_d = S_PUSH_FLAGS; cnt_d = '0; end
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_PUSH_FLAGS: state_d = S_VECTOR;
            S_VECTOR:     state_d = S_IDLE;
            S_CALL_PUSH: begin
                if (last) state_d = S_IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_POP_FLAGS: begin state_d = S_POP_PC; cnt_d = CNT_WORDS; end
            S_POP_PC: begin
                if (last) begin state_d = S_RET_WAIT; cnt_d = CNT_RETW; end
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_RET_WAIT: begin
                if (last) begin
                    state_d = S_IDLE;
                    if (reti_q) in_isr_d = 1'b0;
                    reti_d = 1'b0;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            default: begin state_d = S_IDLE; cnt_d = '0; end
        endcase
    end

    always_comb begin
        busy              = (state_q != S_IDLE);
        pc_write          = !busy;
        clear_instruction = busy;
        jump_uncond       = 1'b0;
        mem_push          = 1'b0;
        mem_pop           = 1'b0;
        mem_src_select    = MSRC_FLAGS;
        word_idx          = '0;
        flag_reg_select   = 1'b0;
        pc_choose_memory  = 1'b0;
        vector_load       = 1'b0;
        irq_ack           = '0;
        case (state_q)
            S_PUSH_PC, S_CALL_PUSH: begin
                mem_push       = 1'b1;
                mem_src_select = MSRC_PC;
                word_idx       = IDX_W'(cnt_q);
                jump_uncond    = (state_q == S_CALL_PUSH) && (cnt_q == CNT_WORDS);
            end
            S_PUSH_FLAGS: mem_push = 1'b1;
            S_VECTOR: begin
                vector_load = 1'b1;
                irq_ack     = N_IRQ'(1) << irq_id_q;
            end
            S_POP_FLAGS: begin
                mem_pop         = 1'b1;
                flag_reg_select = 1'b1;
            end
            S_POP_PC: begin
                // Pop order is the reverse of push order: lower word first.
                mem_pop        = 1'b1;
                mem_src_select = MSRC_PC;
                word_idx       = IDX_W'(CNT_WORDS - cnt_q);
            end
            S_RET_WAIT: pc_choose_memory = (cnt_q == '0);
            default: ;
        endcase
    end

    assign irq_id     = irq_id_q;
    assign state_dbg  = state_q;
    assign in_isr_dbg = in_isr_q;

endmodule

// File: doc/ctrl_flow_sequencer.md
# ctrl_flow_sequencer

Parametrised multi-cycle control-flow sequencer for the decode stage. It owns every instruction that needs more than one cycle of stack traffic: CALL, RET, RETI and hardware interrupt entry. While a sequence runs it stalls fetch, inserts bubbles, and drives the memory-stage push/pop controls word by word. It generalises PC width and stack word width, pipeline drain depth, return latency and the number of prioritised interrupt lines, and adds non-nesting interrupt masking.

## Interface
- `PC_W`, default 32: program counter width.
- `WORD_W`, default 16: stack word width.
  - `PC_WORDS = PC_W/WORD_W`; `PC_W` must be an integer multiple of `WORD_W`.
- `DRAIN`, default 4: bubble cycles inserted before an interrupt push; must be ≥1.
- `RET_WAIT`, default 2: cycles from the last PC pop to the PC data being valid; must be ≥1.
- `N_IRQ`, default 1: number of interrupt request lines; must be ≥1.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `op_valid` in 1: decode presents a control-flow op this cycle.
- `op_kind` in 2: 00 CALL, 01 RET, 10 RETI, 11 reserved (ignored).
- `irq` in `N_IRQ`: level-sensitive interrupt requests; index 0 has highest priority.
- `busy` out 1: a sequence is active; decode holds its instruction.
- `pc_write` out 1: PC may advance; equals `!busy`.
- `clear_instruction` out 1: replace the decode output with a NOP.
- `jump_uncond` out 1: unconditional jump strobe to execute (CALL target).
- `mem_push`, `mem_pop` out 1 each: stack write / stack read strobes.
- `mem_src_select` out 2: 00 flags, 01 PC word, others unused.
- `word_idx` out `max(1,$clog2(PC_WORDS))`: index of the PC word being pushed or popped.
- `flag_reg_select` out 1: the flag register loads from memory data.
- `pc_choose_memory` out 1: one-cycle strobe; PC loads the reassembled popped value.
- `vector_load` out 1: one-cycle strobe; PC loads the interrupt vector selected by `irq_id`.
- `irq_id` out `max(1,$clog2(N_IRQ))`: index of the accepted interrupt; held until the next acceptance.
- `irq_ack` out `N_IRQ`: one-hot acknowledge, one cycle, coincident with `vector_load`.

## Operation
- States:
  - `IDLE`
  - `DRAIN`
  - `PUSH_PC`
  - `PUSH_FLAGS`
  - `VECTOR`
  - `CALL_PUSH`
  - `POP_FLAGS`
  - `POP_PC`
  - `RET_WAIT_S`
- One shared down-counter `cnt`, sized for `max(DRAIN, PC_WORDS, RET_WAIT)`.
- Register `in_isr` marks that an interrupt handler is running.
- All outputs are Moore decodes of `(state, cnt)`. In `IDLE`, every output is 0 except `pc_write` = 1.
- Acceptance happens in `IDLE` only:
  - An interrupt is accepted when `|irq && !in_isr`. It wins over a simultaneous `op_valid`; the held op is re-fetched after the handler returns.
  - Otherwise, `op_valid` with a non-reserved `op_kind` starts that op's sequence.
- CALL: `CALL_PUSH` for `PC_WORDS` cycles.
  - Each cycle: `mem_push`=1, `mem_src_select`=01.
  - `word_idx` runs from `PC_WORDS-1` down to 0 (upper word first).
  - `jump_uncond`=1 in the first cycle only.
  - Then `IDLE`.
- RET: `POP_PC` for `PC_WORDS` cycles.
  - Each cycle: `mem_pop`=1, with `word_idx` running from 0 up to `PC_WORDS-1` (reverse of push order).
  - Then `RET_WAIT_S` for `RET_WAIT` cycles; `pc_choose_memory`=1 in the last of these.
  - Then `IDLE`.
- RETI: `POP_FLAGS` for 1 cycle with `mem_pop`=1, `mem_src_select`=00, `flag_reg_select`=1.
  - Then the RET sequence.
  - `in_isr` clears when returning to `IDLE`.
- Interrupt entry:
  - Capture `irq_id` = lowest set index; set `in_isr`.
  - `DRAIN` for `DRAIN` cycles with `clear_instruction`=1.
  - `PUSH_PC` for `PC_WORDS` cycles, same encoding as `CALL_PUSH` but without `jump_uncond`.
  - `PUSH_FLAGS` for 1 cycle: `mem_push`=1, `mem_src_select`=00.
  - `VECTOR` for 1 cycle: `vector_load`=1, `irq_ack[irq_id]`=1.
  - Then `IDLE`.
- `clear_instruction`=1 in every busy state, so decode never issues while the sequencer is active.
- Boundary conditions:
  - `irq` toggling during a sequence is ignored; only the value sampled in `IDLE` counts.
  - `irq` held across `VECTOR` is masked by `in_isr`; there is no nesting.
  - A reserved `op_kind` keeps the block in `IDLE`.
  - `reset` mid-sequence: next cycle is `IDLE` with `cnt`=0 and `in_isr`=0, and no further push or pop is issued.

## Timing
- Reset values: `busy`=0, `pc_write`=1, all other outputs 0, `irq_id`=0.
- A start condition sampled at edge *n* produces the first sequence outputs in cycle *n+1* (registered state).
- Busy durations:
  - CALL: `PC_WORDS` cycles.
  - RET: `PC_WORDS+RET_WAIT` cycles.
  - RETI: `1+PC_WORDS+RET_WAIT` cycles.
  - Interrupt: `DRAIN+PC_WORDS+2` cycles.
- `pc_write` returns to 1 in the cycle after the final strobe (`pc_choose_memory` or `vector_load`).
- A new op can be accepted back-to-back in the first `IDLE` cycle.

## Structure
- Shared package `ctrl_seq_pkg` holds:
  - `op_kind_e`, the `op_kind` encoding.
  - `seq_state_e`, the state enum.
  - The `mem_src_select` encoding constants `MSRC_FLAGS` and `MSRC_PC`.
- One sub-module, `irq_prio_enc`: parametrised `N_IRQ` lowest-index-wins priority encoder producing `valid` and `id`.

## Test plan
All scenarios use the defaults except `N_IRQ`=4 (so `PC_WORDS`=2, `DRAIN`=4, `RET_WAIT`=2).
- CALL: `op_valid`=1, `op_kind`=00 for one cycle → next 2 cycles `mem_push`=1, `mem_src_select`=01, `word_idx`=1 then 0, `jump_uncond` in the first cycle only, `busy`=1 for exactly 2 cycles.
- RETI: `op_kind`=10 → flag pop with `flag_reg_select`=1, then 2 PC pops with `word_idx` 0,1, `pc_choose_memory` in cycle 5, `busy` 5 cycles.
- Interrupt priority: `irq`=4'b1010 with simultaneous CALL → interrupt wins; 4 `clear_instruction` cycles, pushes idx 1,0 then flags, `vector_load` with `irq_id`=1 and `irq_ack`=4'b0010 in cycle 8, no CALL pushes.
- No nesting: `irq[0]` held high through `VECTOR` and beyond → no second entry until a RETI completes; then re-entry in the first `IDLE` cycle.
- Reset mid-sequence: `reset` asserted during the 2nd `DRAIN` cycle → next cycle `busy`=0, `pc_write`=1, `in_isr`=0, zero pushes ever issued.
- Reserved `op_kind`=11 with `op_valid` → block stays in `IDLE`, all outputs at reset values.
